// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
//   state_e   : controller states (IDLE, RUN, DONE)
//   cnt_width : bit width of an iteration counter that must hold the value n
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: divisor (M), partial remainder (A, N+1 bits),
// quotient/dividend shift register (Q), trial subtractor and result registers.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load                : latch operands, clear A
//   iterate             : perform one shift/subtract/restore step
//   capture             : latch results (post-iteration values, or zero-divide result)
//   zero_div            : with capture, store quotient=all ones, remainder=dividend
//   dividend, divisor   : operands
//   t_msb               : sign of the current trial subtraction
//   quotient, remainder : registered results
module div_datapath #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         iterate,
  input  logic         capture,
  input  logic         zero_div,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         t_msb,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  logic [N-1:0] m_q;
  logic [N:0]   a_q;
  logic [N-1:0] q_q;
  logic [N-1:0] quot_q;
  logic [N-1:0] rem_q;

  logic [N:0]   a_sh;
  logic [N:0]   t;
  logic [N:0]   a_nxt;
  logic [N-1:0] q_nxt;

  // {A,Q} << 1; A never exceeds M after a restore, so its MSB is always 0 here.
  always_comb begin
    a_sh  = {a_q[N-1:0], q_q[N-1]};
    t     = a_sh - {1'b0, m_q};
    t_msb = t[N];
    if (t[N]) begin
      a_nxt = a_sh;
      q_nxt = {q_q[N-2:0], 1'b0};
    end else begin
      a_nxt = t;
      q_nxt = {q_q[N-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      a_q <= '0;
      q_q <= '0;
    end else if (load) begin
      m_q <= divisor;
      a_q <= '0;
      q_q <= dividend;
    end else if (iterate) begin
      a_q <= a_nxt;
      q_q <= q_nxt;
    end
  end

  // Capture happens on the same edge as the final iteration, so take next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
    end else if (capture) begin
      if (zero_div) begin
        quot_q <= '1;
        rem_q  <= dividend;
      end else begin
        quot_q <= q_nxt;
        rem_q  <= a_nxt[N-1:0];
      end
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/restoring_divider.sv
// N-bit unsigned restoring divider: one quotient bit per RUN cycle, N cycles per
// division; a zero divisor completes immediately with div_by_zero set.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a division (accepted in IDLE or DONE only)
//   dividend, divisor   : operands, sampled when start is accepted
//   busy                : iteration sequence in progress
//   done                : one-cycle pulse, results valid from this cycle
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : last accepted division had divisor == 0
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = cnt_width(N);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;

  logic load;
  logic iterate;
  logic capture;
  logic zero_div;
  logic t_msb;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;
    load     = 1'b0;
    iterate  = 1'b0;
    capture  = 1'b0;
    zero_div = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            load    = 1'b1;
            cnt_d   = CW'(N);
            dz_d    = 1'b0;
          end else begin
            state_d  = DONE;
            capture  = 1'b1;
            zero_div = 1'b1;
            dz_d     = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // start is deliberately ignored here
        iterate = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          capture = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  div_datapath #(
    .N(N)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .iterate  (iterate),
    .capture  (capture),
    .zero_div (zero_div),
    .dividend (dividend),
    .divisor  (divisor),
    .t_msb    (t_msb),
    .quotient (quotient),
    .remainder(remainder)
  );

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  restoring_divider #(
    .N(N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dd;
    logic [N-1:0] dv;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge. Returns edges from acceptance to done and busy samples seen.
  task automatic run_div(input logic [N-1:0] dd, input logic [N-1:0] dv,
                         output int lat, output int bcnt);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int ndone;
    int nbusy;
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         edz;
    int           elat;

    vecs[0] = '{dd: 4'd13, dv: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0, lat: 4};
    vecs[1] = '{dd: 4'd15, dv: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0, lat: 4};
    vecs[2] = '{dd: 4'd3,  dv: 4'd9,  q: 4'd0,  r: 4'd3, dz: 1'b0, lat: 4};
    vecs[3] = '{dd: 4'd15, dv: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0, lat: 4};
    vecs[4] = '{dd: 4'd7,  dv: 4'd0,  q: 4'd15, r: 4'd7, dz: 1'b1, lat: 0};
    vecs[5] = '{dd: 4'd0,  dv: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0, lat: 4};
    vecs[6] = '{dd: 4'd9,  dv: 4'd2,  q: 4'd4,  r: 4'd1, dz: 1'b0, lat: 4};
    vecs[7] = '{dd: 4'd14, dv: 4'd4,  q: 4'd3,  r: 4'd2, dz: 1'b0, lat: 4};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].dd, vecs[i].dv, lat, bcnt);
      chk($sformatf("vec%0d_quotient", i), int'(quotient), int'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), int'(remainder), int'(vecs[i].r));
      chk($sformatf("vec%0d_dz", i), int'(div_by_zero), int'(vecs[i].dz));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].lat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_single", i), int'(done), 0);
      chk($sformatf("vec%0d_hold_quotient", i), int'(quotient), int'(vecs[i].q));
    end

    // start pulsed mid-RUN must be ignored
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dividend = 4'd2;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 2;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore_latency", lat, 4);
    chk("ignore_quotient", int'(quotient), 4);
    chk("ignore_remainder", int'(remainder), 1);
    chk("ignore_dz", int'(div_by_zero), 0);
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("ignore_extra_done", ndone, 0);

    // Reset on the second RUN cycle abandons the division
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_dz", int'(div_by_zero), 0);
    rst   = 1'b0;
    ndone = 0;
    nbusy = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_no_busy", nbusy, 0);

    // Exhaustive back-to-back sweep: next operands presented during the DONE cycle
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair     = i[7:0];
      dividend = pair[7:4];
      divisor  = pair[3:0];
      start    = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!done && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      if (pair[3:0] == 4'd0) begin
        eq   = 4'hf;
        er   = pair[7:4];
        edz  = 1'b1;
        elat = 0;
      end else begin
        eq   = pair[7:4] / pair[3:0];
        er   = pair[7:4] % pair[3:0];
        edz  = 1'b0;
        elat = 4;
      end
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edz || lat != elat) begin
        failures++;
        $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%0d lat=%0d expected q=%0d r=%0d dz=%0d lat=%0d",
                 pair[7:4], pair[3:0], quotient, remainder, div_by_zero, lat, eq, er, edz, elat);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("sweep_end_idle", int'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter N, default 4, SHALL set the operand width in bits (N >= 2).
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request to begin a division; sampled only in IDLE or DONE.
REQ-005 dividend  in  N  unsigned dividend; sampled on the cycle start is accepted.
REQ-006 divisor  in  N  unsigned divisor; sampled on the cycle start is accepted.
REQ-007 busy  out  1  high while an iteration sequence is in progress.
REQ-008 done  out  1  single-cycle pulse; results are valid from this cycle.
REQ-009 quotient  out  N  unsigned quotient.
REQ-010 remainder  out  N  unsigned remainder.
REQ-011 div_by_zero  out  1  high when the last accepted division had divisor == 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE or DONE, start=1, divisor!=0 -> RUN; on the same edge:
  - M <= divisor
  - Q <= dividend
  - A (N+1 bits) <= 0
  - iteration counter <= N
  - div_by_zero <= 0
REQ-014 IDLE or DONE, start=1, divisor==0 -> DONE; on the same edge:
  - quotient <= all ones
  - remainder <= dividend
  - div_by_zero <= 1
REQ-015 IDLE, start=0 -> IDLE; DONE, start=0 -> IDLE.
REQ-016 Each RUN cycle SHALL perform one restoring iteration:
  - form {A,Q} shifted left by 1
  - compute T = A_shifted - {1'b0,M} in N+1 bits
  - T MSB = 1 -> A <= A_shifted, Q[0] <= 0
  - T MSB = 0 -> A <= T, Q[0] <= 1
  - decrement the counter
REQ-017 RUN SHALL transition to DONE on the edge that completes the iteration where the counter equals 1 (N RUN cycles total).
REQ-018 On entry to DONE from RUN: quotient <= Q, remainder <= A[N-1:0].
REQ-019 done SHALL equal (state == DONE); busy SHALL equal (state == RUN).
REQ-020 Latency: an accepted start at edge k SHALL give done high in the cycle after edge k+N (nonzero divisor), or in the cycle after edge k (zero divisor).
REQ-021 start while in RUN SHALL be ignored; operands and in-flight state SHALL be unchanged.
REQ-022 quotient, remainder and div_by_zero SHALL hold their last values until the next accepted start or reset.
REQ-023 start asserted in DONE SHALL begin a new division with no idle cycle (back-to-back operation).
REQ-024 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor != 0.

Reset
REQ-025 rst=1 SHALL, at the next edge:
  - force state to IDLE
  - clear A, Q, M and the counter
  - clear quotient, remainder and div_by_zero
REQ-026 During and after reset, busy and done SHALL read 0.
REQ-027 rst SHALL take priority over start and over any RUN iteration; reset mid-operation abandons the division with no done pulse.

Structure
REQ-028 Package div_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the counter-width function clog2(N+1).
REQ-029 One sub-module, div_datapath, SHALL hold M, A, Q, the trial subtractor and the shift logic.
  - Controls: load, iterate, capture.
  - Status: T MSB.
REQ-030 The FSM and counter SHALL reside in restoring_divider, which instantiates div_datapath.

Verification
REQ-031 N=4, dividend=13, divisor=3, start 1 cycle -> busy for 4 cycles, then done=1 with quotient=4, remainder=1, div_by_zero=0.
REQ-032 N=4, 15/1 -> quotient=15, remainder=0; 3/9 -> quotient=0, remainder=3; 15/15 -> quotient=1, remainder=0.
REQ-033 N=4, 7/0 -> done one cycle after start, quotient=15, remainder=7, div_by_zero=1, busy never high.
REQ-034 N=4, 13/3 started, start pulsed with 2/1 during RUN -> result remains 4 r 1; no extra done pulse.
REQ-035 N=4, 13/3 started, rst asserted on the 2nd RUN cycle -> next cycle busy=0, done=0, all outputs 0; no done pulse follows.
REQ-036 Exhaustive N=4 sweep of all 256 operand pairs, issued back-to-back by asserting start in DONE -> every result satisfies REQ-024 or REQ-014.
